// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - shares one RAM port between icache and dcache block bursts.
// Round-robin grant on contention, WORDS-word burst sequencing, abort on dropped request.
module cache_mem_arbiter #(
  parameter int WORDS  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       iREN,
  input  logic [ADDR_W-1:0]          iaddr,
  output logic [DATA_W-1:0]          iload,
  output logic                       iwait,
  output logic [$clog2(WORDS)-1:0]   iword,
  output logic                       idone,
  input  logic                       dREN,
  input  logic                       dWEN,
  input  logic [ADDR_W-1:0]          daddr,
  input  logic [DATA_W-1:0]          dstore,
  output logic [DATA_W-1:0]          dload,
  output logic                       dwait,
  output logic [$clog2(WORDS)-1:0]   dword,
  output logic                       ddone,
  output logic                       ramREN,
  output logic                       ramWEN,
  output logic [ADDR_W-1:0]          ramaddr,
  output logic [DATA_W-1:0]          ramstore,
  input  logic [DATA_W-1:0]          ramload,
  input  logic                       ramready
);

  localparam int CW  = $clog2(WORDS);
  localparam int LSB = CW + 2;
  localparam logic [ADDR_W-1:0] BASE_MASK = ~(ADDR_W'((1 << LSB) - 1));

  typedef enum logic [1:0] {IDLE, IBURST, DBURST} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_count;
  logic            r_last_d;

  logic              w_ireq;
  logic              w_dreq;
  logic              w_grant_d;
  logic              w_active;
  logic              w_xfer;
  logic              w_last;
  logic [ADDR_W-1:0] w_offset;
  logic [ADDR_W-1:0] w_ibase;
  logic [ADDR_W-1:0] w_dbase;

  assign w_ireq    = iREN;
  assign w_dreq    = dREN | dWEN;
  // On contention the side that did not win last time gets the port.
  assign w_grant_d = w_dreq & (~w_ireq | ~r_last_d);
  assign w_active  = ((r_state == IBURST) & w_ireq) | ((r_state == DBURST) & w_dreq);
  assign w_xfer    = w_active & ramready;
  assign w_last    = (r_count == CW'(WORDS - 1));
  assign w_offset  = {{(ADDR_W - LSB){1'b0}}, r_count, 2'b00};
  assign w_ibase   = iaddr & BASE_MASK;
  assign w_dbase   = daddr & BASE_MASK;

  assign iload = ramload;
  assign dload = ramload;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_last_d <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_count <= '0;
          if (w_ireq | w_dreq) begin
            r_state  <= w_grant_d ? DBURST : IBURST;
            r_last_d <= w_grant_d;
          end
        end
        IBURST, DBURST: begin
          if (!w_active) begin
            r_state <= IDLE;
            r_count <= '0;
          end else if (ramready) begin
            if (w_last) begin
              r_state <= IDLE;
              r_count <= '0;
            end else begin
              r_count <= r_count + CW'(1);
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_count <= '0;
        end
      endcase
    end
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    idone    = 1'b0;
    iword    = '0;
    dwait    = 1'b1;
    ddone    = 1'b0;
    dword    = '0;
    case (r_state)
      IBURST: begin
        ramREN  = w_ireq;
        ramaddr = w_ibase + w_offset;
        iword   = r_count;
        iwait   = ~w_xfer;
        idone   = w_xfer & w_last;
      end
      DBURST: begin
        // A write-back takes precedence when both dcache strobes are up.
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = w_dbase + w_offset;
        ramstore = dWEN ? dstore : '0;
        dword    = r_count;
        dwait    = ~w_xfer;
        ddone    = w_xfer & w_last;
      end
      default: begin
        ramREN = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - directed vector bench for cache_mem_arbiter.
module tb_cache_mem_arbiter;

  localparam logic [31:0] K = 32'h5A5A0000;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN, dREN, dWEN, ramready;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic        iwait, idone, dwait, ddone, ramREN, ramWEN;
  logic [1:0]  iword, dword;

  always #5 CLK = ~CLK;

  assign ramload = ramaddr ^ K;
  assign dstore  = 32'hA0 + 32'(dword);

  cache_mem_arbiter #(.WORDS(4), .ADDR_W(32), .DATA_W(32)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait), .iword(iword), .idone(idone),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dload(dload),
    .dwait(dwait), .dword(dword), .ddone(ddone),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramready(ramready)
  );

  typedef struct {
    string       nm;
    logic        rst;
    logic        i, d, w;
    logic [31:0] ia, da;
    logic        rr;
    logic        care;
    logic [9:0]  ctl;
    logic [31:0] addr, store;
  } vec_t;

  vec_t vq[$];
  int   n_pass = 0;
  int   n_total = 0;

  function automatic logic [9:0] c(logic ren, logic wen, logic iw, logic id, logic [1:0] iwd,
                                   logic dw, logic dd, logic [1:0] dwd);
    return {ren, wen, iw, id, iwd, dw, dd, dwd};
  endfunction

  localparam logic [9:0] IDL = 10'b00_10_00_10_00;

  function automatic void add(string nm, logic rst, logic i, logic d, logic w,
                              logic [31:0] ia, logic [31:0] da, logic rr, logic care,
                              logic [9:0] ctl, logic [31:0] addr, logic [31:0] store);
    vec_t v;
    v.nm = nm; v.rst = rst; v.i = i; v.d = d; v.w = w; v.ia = ia; v.da = da;
    v.rr = rr; v.care = care; v.ctl = ctl; v.addr = addr; v.store = store;
    vq.push_back(v);
  endfunction

  function automatic void burst(string nm, logic i, logic d, logic w, logic [31:0] ia,
                                logic [31:0] da, logic isd, logic [31:0] base);
    for (int k = 0; k < 4; k++) begin
      if (isd)
        add(nm, 0, i, d, w, ia, da, 1, 1, c(~w, w, 1, 0, 2'd0, 0, k == 3, 2'(k)),
            base + 32'(4 * k), w ? 32'hA0 + 32'(k) : 32'h0);
      else
        add(nm, 0, i, d, w, ia, da, 1, 1, c(1, 0, 0, k == 3, 2'(k), 1, 0, 2'd0),
            base + 32'(4 * k), 32'h0);
    end
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  initial begin
    logic [9:0] m;
    logic [9:0] act;
    logic       rp[7] = '{1, 0, 0, 1, 1, 0, 1};
    int         cnt;

    // lone icache read, unaligned base forced to block boundary
    add("iread", 0, 1, 0, 0, 32'h104, 0, 1, 1, IDL, 0, 0);
    burst("iread", 1, 0, 0, 32'h104, 0, 0, 32'h100);
    add("iread", 0, 0, 0, 0, 0, 0, 1, 1, IDL, 0, 0);
    // dcache write-back
    add("dwrite", 0, 0, 0, 1, 0, 32'h20, 1, 1, IDL, 0, 0);
    burst("dwrite", 0, 0, 1, 0, 32'h20, 1, 32'h20);
    add("dwrite", 0, 0, 0, 0, 0, 0, 1, 1, IDL, 0, 0);
    // contention from reset: D, I, D, I
    add("cont", 1, 1, 1, 0, 32'h200, 32'h40, 1, 1, IDL, 0, 0);
    burst("cont_d1", 1, 1, 0, 32'h200, 32'h40, 1, 32'h40);
    add("cont", 0, 1, 1, 0, 32'h200, 32'h40, 1, 1, IDL, 0, 0);
    burst("cont_i1", 1, 1, 0, 32'h200, 32'h40, 0, 32'h200);
    add("cont", 0, 1, 1, 0, 32'h200, 32'h40, 1, 1, IDL, 0, 0);
    burst("cont_d2", 1, 1, 0, 32'h200, 32'h40, 1, 32'h40);
    add("cont", 0, 1, 1, 0, 32'h200, 32'h40, 1, 1, IDL, 0, 0);
    burst("cont_i2", 1, 1, 0, 32'h200, 32'h40, 0, 32'h200);
    add("cont", 0, 0, 0, 0, 0, 0, 1, 1, IDL, 0, 0);
    // ramready stalls
    add("stall", 0, 1, 0, 0, 32'h300, 0, 1, 1, IDL, 0, 0);
    cnt = 0;
    for (int p = 0; p < 7; p++) begin
      add("stall", 0, 1, 0, 0, 32'h300, 0, rp[p], 1,
          c(1, 0, ~rp[p], rp[p] && cnt == 3, 2'(cnt), 1, 0, 2'd0), 32'h300 + 32'(4 * cnt), 0);
      if (rp[p]) cnt++;
    end
    add("stall", 0, 0, 0, 0, 0, 0, 1, 1, IDL, 0, 0);
    // dREN dropped after two words, then restart from word 0
    add("abort", 0, 0, 1, 0, 0, 32'h8C, 1, 1, IDL, 0, 0);
    add("abort", 0, 0, 1, 0, 0, 32'h8C, 1, 1, c(1, 0, 1, 0, 2'd0, 0, 0, 2'd0), 32'h80, 0);
    add("abort", 0, 0, 1, 0, 0, 32'h8C, 1, 1, c(1, 0, 1, 0, 2'd0, 0, 0, 2'd1), 32'h84, 0);
    add("abort_drop", 0, 0, 0, 0, 0, 32'h8C, 1, 0, IDL, 0, 0);
    add("abort_idle", 0, 0, 0, 0, 0, 32'h8C, 1, 1, IDL, 0, 0);
    add("restart", 0, 0, 1, 0, 0, 32'h8C, 1, 1, IDL, 0, 0);
    burst("restart", 0, 1, 0, 0, 32'h8C, 1, 32'h80);
    add("restart", 0, 0, 0, 0, 0, 0, 1, 1, IDL, 0, 0);

    // reset state, with requests present during reset
    RST = 1; iREN = 1; dREN = 0; dWEN = 1; iaddr = 32'h104; daddr = 32'h20; ramready = 1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("reset ctl", 64'({ramREN, ramWEN, iwait, idone, iword, dwait, ddone, dword}), 64'(IDL));
    chk("reset addr/store", {ramaddr, ramstore}, 64'h0);
    iREN = 0; dWEN = 0;
    RST = 0;

    foreach (vq[n]) begin
      @(posedge CLK); #1;
      if (vq[n].rst) begin RST = 1; #1; RST = 0; end
      iREN = vq[n].i; dREN = vq[n].d; dWEN = vq[n].w;
      iaddr = vq[n].ia; daddr = vq[n].da; ramready = vq[n].rr;
      @(negedge CLK);
      act = {ramREN, ramWEN, iwait, idone, iword, dwait, ddone, dword};
      m = vq[n].care ? 10'h3FF : 10'b11_11_00_11_00;
      chk($sformatf("%s[%0d] ctl", vq[n].nm, n), 64'(act & m), 64'(vq[n].ctl & m));
      if (vq[n].care) begin
        chk($sformatf("%s[%0d] ramaddr", vq[n].nm, n), 64'(ramaddr), 64'(vq[n].addr));
        chk($sformatf("%s[%0d] ramstore", vq[n].nm, n), 64'(ramstore), 64'(vq[n].store));
        chk($sformatf("%s[%0d] loads", vq[n].nm, n), {iload, dload},
            {vq[n].addr ^ K, vq[n].addr ^ K});
      end
    end

    // asynchronous reset in the middle of the second icache word
    @(posedge CLK); #1;
    iREN = 1; iaddr = 32'h400; dREN = 0; dWEN = 0; daddr = 32'h40; ramready = 1;
    @(posedge CLK); #1;
    chk("rst_mid word0", 64'({ramREN, iwait, iword}), 64'({1'b1, 1'b0, 2'd0}));
    @(posedge CLK); #1;
    ramready = 0;
    #1;
    chk("rst_mid word1 pre", {ramaddr, 29'd0, ramREN, iword}, {32'h404, 29'd0, 1'b1, 2'd1});
    RST = 1; dREN = 1;
    #1;
    chk("rst_mid strobes", 64'({ramREN, ramWEN, iwait, iword, dwait}), 64'({1'b0, 1'b0, 1'b1, 2'd0, 1'b1}));
    chk("rst_mid addr", 64'(ramaddr), 64'h0);
    ramready = 1;
    @(negedge CLK);
    RST = 0;
    @(posedge CLK); #1;
    chk("post_rst grant d", 64'({ramREN, ramWEN, dwait, iwait, dword}), 64'({1'b1, 1'b0, 1'b0, 1'b1, 2'd0}));
    chk("post_rst addr", 64'(ramaddr), 64'h40);
    iREN = 0; dREN = 0;
    repeat (2) @(posedge CLK);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
